// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for hazards that forwarding cannot cover: load-use, multi-cycle loads, taken branches.
// Control outputs are combinational from state and inputs; the freeze/bubble performance counters are registered.
module hazard_stall_unit #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic             ID_UsesRs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             MEM_MemRead_i,
  input  logic             Flush_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IDEX_Bubble_o,
  output logic             IFID_Flush_o,
  output logic             Freeze_o,
  output logic [CNT_W-1:0] FreezeCnt_o,
  output logic [CNT_W-1:0] BubbleCnt_o
);

  localparam int WC_W = $clog2(LOAD_LAT) + 1;
  localparam logic [WC_W-1:0] WC_RELOAD = (LOAD_LAT > 1) ? WC_W'(LOAD_LAT - 2) : '0;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state;
  logic [WC_W-1:0] wait_cnt;
  logic            start_wait;
  logic            load_use;
  logic            freeze;

  // A single-cycle load (LOAD_LAT=1) never leaves RUN and never freezes.
  assign start_wait = (state == RUN) && MEM_MemRead_i && (LOAD_LAT > 1);
  assign freeze     = !rst_i && (start_wait || ((state == WAIT) && (wait_cnt != '0)));

  assign load_use = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
                    ((EX_Rd_i == ID_Rs1_i) || (ID_UsesRs2_i && (EX_Rd_i == ID_Rs2_i)));

  always_comb begin
    PCWrite_o     = 1'b0;
    IFID_Write_o  = 1'b0;
    IDEX_Bubble_o = 1'b0;
    IFID_Flush_o  = 1'b0;
    Freeze_o      = 1'b0;
    if (rst_i) begin
      Freeze_o = 1'b0;
    end else if (freeze) begin
      Freeze_o = 1'b1;
    end else if (load_use) begin
      // A concurrent branch flush is dropped; the branch source re-asserts it.
      IDEX_Bubble_o = 1'b1;
    end else if (Flush_i) begin
      PCWrite_o    = 1'b1;
      IFID_Write_o = 1'b1;
      IFID_Flush_o = 1'b1;
    end else begin
      PCWrite_o    = 1'b1;
      IFID_Write_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (start_wait) begin
            state    <= WAIT;
            wait_cnt <= WC_RELOAD;
          end
        end
        default: begin
          // The final WAIT cycle lets the load leave MEM without retriggering.
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WC_W'(1);
          end else begin
            state <= RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      FreezeCnt_o <= '0;
      BubbleCnt_o <= '0;
    end else begin
      if (Freeze_o && (FreezeCnt_o != '1)) begin
        FreezeCnt_o <= FreezeCnt_o + CNT_W'(1);
      end
      if (IDEX_Bubble_o && (BubbleCnt_o != '1)) begin
        BubbleCnt_o <= BubbleCnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench: three hazard_stall_unit configurations share one randomized stimulus stream,
// each checked every cycle against a cycle-age reference model of the hazard rules.
module tb_hazard_stall_unit;

  typedef struct packed {
    logic [4:0]  ctrl;  // {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush, Freeze}
    logic [15:0] fc;
    logic [15:0] bc;
  } exp_t;

  typedef exp_t [2:0] exp3_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs2 = 1'b0, ex_mem_read = 1'b0, mem_mem_read = 1'b0, flush = 1'b0;

  logic [2:0]  pcw, ifw, bub, flu, frz;
  logic [15:0] fcnt [3];
  logic [15:0] bcnt [3];

  int n_checks = 0;
  int n_fail   = 0;

  exp3_t sb_q[$];

  int     age  [3];
  longint nfrz [3];
  longint nbub [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LL = (g == 0) ? 2 : (g == 1) ? 4 : 3;
    localparam int CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] fc, bc;
    hazard_stall_unit #(.LOAD_LAT(LL), .CNT_W(CW)) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .ID_Rs1_i      (id_rs1),
      .ID_Rs2_i      (id_rs2),
      .ID_UsesRs2_i  (id_uses_rs2),
      .EX_MemRead_i  (ex_mem_read),
      .EX_Rd_i       (ex_rd),
      .MEM_MemRead_i (mem_mem_read),
      .Flush_i       (flush),
      .PCWrite_o     (pcw[g]),
      .IFID_Write_o  (ifw[g]),
      .IDEX_Bubble_o (bub[g]),
      .IFID_Flush_o  (flu[g]),
      .Freeze_o      (frz[g]),
      .FreezeCnt_o   (fc),
      .BubbleCnt_o   (bc)
    );
    assign fcnt[g] = 16'(fc);
    assign bcnt[g] = 16'(bc);
  end

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 4 : 3;
  endfunction

  function automatic logic [15:0] sat(longint n, int g);
    longint mx;
    mx = (g == 2) ? 64'd3 : 64'd65535;
    return 16'((n < mx) ? n : mx);
  endfunction

  // One cycle of stimulus: drive inputs, predict every instance, queue the prediction.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic exm, input logic [4:0] exrd, input logic memr,
                      input logic fl, input logic r);
    exp3_t e;
    logic  lu, f, b;
    int    L, cyc;
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2;
    ex_mem_read = exm; ex_rd = exrd; mem_mem_read = memr; flush = fl; rst = r;
    lu = exm && (exrd != 5'd0) && ((exrd == rs1) || (u2 && (exrd == rs2)));
    for (int g = 0; g < 3; g++) begin
      if (r) begin
        age[g] = 0; nfrz[g] = 0; nbub[g] = 0;
        e[g] = '{ctrl: 5'b00000, fc: 16'd0, bc: 16'd0};
      end else begin
        L = lat_of(g);
        // cyc = 1-based cycle index of the load currently held in MEM (0 = none)
        if (age[g] > 0) cyc = age[g] + 1;
        else if (memr && L > 1) cyc = 1;
        else cyc = 0;
        f = (cyc != 0) && (cyc <= L - 1);
        b = !f && lu;
        e[g].fc = sat(nfrz[g], g);
        e[g].bc = sat(nbub[g], g);
        if (f)       e[g].ctrl = 5'b00001;
        else if (lu) e[g].ctrl = 5'b00100;
        else if (fl) e[g].ctrl = 5'b11010;
        else         e[g].ctrl = 5'b11000;
        nfrz[g] += f ? 1 : 0;
        nbub[g] += b ? 1 : 0;
        age[g] = (cyc == 0 || cyc == L) ? 0 : cyc;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input int g, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, g, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle once inputs have settled after the falling edge.
  initial begin
    exp3_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int g = 0; g < 3; g++) begin
          chk("ctrl", g, {11'd0, pcw[g], ifw[g], bub[g], flu[g], frz[g]}, {11'd0, e[g].ctrl});
          chk("freeze_cnt", g, fcnt[g], e[g].fc);
          chk("bubble_cnt", g, bcnt[g], e[g].bc);
        end
      end
    end
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      age[g] = 0; nfrz[g] = 0; nbub[g] = 0;
    end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on x5, x0 destination, rs2 match with and without rs2 use
    step(5, 0, 1, 1, 5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 5, 0, 1, 5, 0, 0, 0);
    step(1, 5, 1, 1, 5, 0, 0, 0);
    // flush with and without load-use
    step(5, 0, 0, 1, 5, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    // two consecutive multi-cycle loads
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // freeze overlapping load-use and flush
    for (int i = 0; i < 5; i++) step(7, 0, 0, 1, 7, (i < 4) ? 1'b1 : 1'b0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a wait
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
